// File: rtl/rnf_txreq_pkg.sv
// Shared CHI definitions for the RN-F request path: REQ flit layout, node IDs,
// credit defaults and link-activation states.
package rnf_txreq_pkg;

  localparam int numCreditsForHNReq [1] = '{8};
  localparam int RNId [1] = '{3};
  localparam int HNId [1] = '{12};

  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  tgt_id;
    logic [6:0]  src_id;
    logic [7:0]  txn_id;
    logic [5:0]  opcode;
    logic [2:0]  size;
    logic [31:0] addr;
  } reqflit_t;

  typedef enum logic [1:0] {
    LINK_STOP,
    LINK_ACTIVATE,
    LINK_RUN,
    LINK_DEACTIVATE
  } link_state_t;

endpackage

// File: rtl/rnf_txnid_pool.sv
// TxnID allocator: busy bitmap with lowest-free selection. A release only
// frees its id for the following cycle, since selection looks at the registered bitmap.
module rnf_txnid_pool #(
  parameter int NUM_TXN = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc,
  input  logic       release_valid,
  input  logic [7:0] release_id,
  output logic [7:0] alloc_id,
  output logic       full
);

  logic [NUM_TXN-1:0] busy_q;
  logic [NUM_TXN-1:0] alloc_mask;
  logic [NUM_TXN-1:0] release_mask;
  logic               release_ok;

  always_comb begin
    alloc_id = '0;
    for (int i = NUM_TXN - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_id = 8'(i);
    end
  end

  assign full = &busy_q;

  always_comb begin
    alloc_mask   = '0;
    release_mask = '0;
    release_ok   = 1'b0;
    for (int i = 0; i < NUM_TXN; i++) begin
      if (alloc && !full && (alloc_id == 8'(i))) alloc_mask[i] = 1'b1;
      if (release_valid && (release_id == 8'(i)) && busy_q[i]) begin
        release_mask[i] = 1'b1;
        release_ok      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q | alloc_mask) & ~release_mask;
      if (release_valid) begin
        assert (release_ok) else $error("txnid release of idle or out-of-range id %0d", release_id);
      end
    end
  end

endmodule

// File: rtl/rnf_txreq.sv
// RN-F TX REQ link stage: link activation FSM, link-credit counter, TxnID
// allocation and a one-cycle registered flit launch.
module rnf_txreq
  import rnf_txreq_pkg::*;
#(
  parameter int MAX_CRD = numCreditsForHNReq[0],
  parameter int NUM_TXN = numCreditsForHNReq[0],
  parameter int RN_ID   = RNId[0],
  parameter int HN_ID   = HNId[0]
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         link_en,
  input  reqflit_t                     req_flit,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic [7:0]                   req_txnid,
  input  logic                         txn_done_valid,
  input  logic [7:0]                   txn_done_id,
  output logic                         TXLINKACTIVEREQ,
  input  logic                         TXLINKACTIVEACK,
  output reqflit_t                     TXREQFLIT,
  output logic                         TXREQFLITV,
  output logic                         TXREQFLITPEND,
  input  logic                         TXREQLCRDV,
  output logic [$clog2(MAX_CRD+1)-1:0] credit_cnt
);

  localparam int CRD_W = $clog2(MAX_CRD + 1);

  link_state_t      state;
  logic             link_req_q;
  logic [CRD_W-1:0] crd_q;
  logic             pool_full;
  logic [7:0]       alloc_id;
  logic             can_send;
  logic             accept;
  logic             crd_inc;
  reqflit_t         stamped;
  reqflit_t         flit_p1;
  logic             vld_p1;

  function automatic logic [CRD_W-1:0] crd_sat_inc(input logic [CRD_W-1:0] c);
    return (c == CRD_W'(MAX_CRD)) ? c : c + 1'b1;
  endfunction

  assign can_send = (state == LINK_RUN) && (crd_q != '0) && !pool_full;
  assign accept   = req_valid && can_send;
  assign crd_inc  = TXREQLCRDV && (state != LINK_STOP);

  rnf_txnid_pool #(.NUM_TXN(NUM_TXN)) u_pool (
    .clock         (clock),
    .reset         (reset),
    .alloc         (accept),
    .release_valid (txn_done_valid),
    .release_id    (txn_done_id),
    .alloc_id      (alloc_id),
    .full          (pool_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= LINK_STOP;
      link_req_q <= 1'b0;
    end else begin
      case (state)
        LINK_STOP: if (link_en) begin
          state      <= LINK_ACTIVATE;
          link_req_q <= 1'b1;
        end
        LINK_ACTIVATE: if (TXLINKACTIVEACK) state <= LINK_RUN;
        LINK_RUN: if (!link_en) begin
          state      <= LINK_DEACTIVATE;
          link_req_q <= 1'b0;
        end
        LINK_DEACTIVATE: if (!TXLINKACTIVEACK) state <= LINK_STOP;
        default: begin
          state      <= LINK_STOP;
          link_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Credits granted to a link that has gone back to STOP are forfeit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      crd_q <= '0;
    end else if ((state == LINK_DEACTIVATE) && !TXLINKACTIVEACK) begin
      crd_q <= '0;
    end else if (crd_inc && !accept) begin
      assert (crd_q != CRD_W'(MAX_CRD)) else $error("link credit overflow");
      crd_q <= crd_sat_inc(crd_q);
    end else if (!crd_inc && accept) begin
      crd_q <= crd_q - 1'b1;
    end
  end

  always_comb begin
    stamped        = req_flit;
    stamped.txn_id = alloc_id;
    stamped.src_id = 7'(RN_ID);
    stamped.tgt_id = 7'(HN_ID);
  end

  // Stage p1: launch register, valid for exactly the cycle after accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      flit_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) flit_p1 <= stamped;
    end
  end

  assign req_ready       = can_send;
  assign TXREQFLITPEND   = can_send;
  assign req_txnid       = alloc_id;
  assign TXLINKACTIVEREQ = link_req_q;
  assign TXREQFLIT       = flit_p1;
  assign TXREQFLITV      = vld_p1;
  assign credit_cnt      = crd_q;

endmodule
